// File: rtl/mc_ctl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mc_ctl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    FETCH_W = 4'd2,
    DECODE  = 4'd3,
    MEMADR  = 4'd4,
    MEMRD   = 4'd5,
    MEMWB   = 4'd6,
    MEMWR   = 4'd7,
    REXEC   = 4'd8,
    RWB     = 4'd9,
    BEQ     = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctl_decode.sv
// Combinational state -> datapath control word decode (Moore outputs).
module mc_ctl_decode
  import mc_ctl_pkg::*;
(
  input  state_t     state,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       M2R,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    M2R         = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUop       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state)
      FETCH:   MemRead = 1'b1;
      // IR/PC loads live in their own state so they never depend on mem_ready
      FETCH_W: begin
        IRWrite  = 1'b1;
        PCWrite  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUop    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
      end
      DECODE:  ALUSrcB = SRCB_IMM_SH;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        M2R      = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      REXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_FUNCT;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctl.sv
// Multi-cycle MIPS main controller: state register, sequencing, illegal flag, retire counter.
module multi_cycle_ctl
  import mc_ctl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             M2R,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUop,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state;
  logic   rdy;
  logic   retire;

  assign rdy     = mem_ready | (MEM_WAIT_EN == 0);
  assign retire  = (state == MEMWB) | (state == RWB) | (state == BEQ) |
                   (state == JUMP)  | ((state == MEMWR) & rdy);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      illegal <= 1'b0;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (rdy) state <= FETCH_W;
        FETCH_W: state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= REXEC;
            OP_BEQ:       state <= BEQ;
            OP_J:         state <= JUMP;
            default: begin
              state   <= FETCH;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR:  state <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (rdy) state <= MEMWB;
        MEMWR:   if (rdy) state <= FETCH;
        REXEC:   state <= RWB;
        default: state <= FETCH;
      endcase
    end
  end

  mc_ctl_decode u_decode (
    .state       (state),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .M2R         (M2R),
    .PCSource    (PCSource),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst)
  );

endmodule
